// File: rtl/vga_pkg.sv
// vga_pkg: shared timing types and the 640x480@60 preset
package vga_pkg;
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;
  localparam int unsigned VGA640_CLK_DIV = 2;
  localparam vga_axis_t VGA640_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_axis_t VGA640_V = '{active: 480, fp: 10, sync: 2, bp: 33};
  function automatic int max_i(int a, int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/clk_div_ce.sv
// clk_div_ce: pixel clock-enable divider and registered VGA_CLK level
module clk_div_ce #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic ce,
  output logic vclk
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] HALF = W'(DIV / 2);
  logic [W-1:0] cnt;
  logic [W-1:0] nxt;
  assign ce = en && cnt == LAST;
  assign nxt = cnt == LAST ? '0 : cnt + W'(1);
  // vclk follows the next count so it falls on the same edge the pixel outputs load
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      vclk <= 1'b0;
    end else if (en) begin
      cnt <= nxt;
      vclk <= nxt >= HALF;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel strobes and coordinates
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = int'(VGA640_CLK_DIV),
  parameter int H_ACTIVE = int'(VGA640_H.active),
  parameter int H_FP     = int'(VGA640_H.fp),
  parameter int H_SYNC   = int'(VGA640_H.sync),
  parameter int H_BP     = int'(VGA640_H.bp),
  parameter int V_ACTIVE = int'(VGA640_V.active),
  parameter int V_FP     = int'(VGA640_V.fp),
  parameter int V_SYNC   = int'(VGA640_V.sync),
  parameter int V_BP     = int'(VGA640_V.bp),
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int CW      = $clog2(max_i(H_TOTAL, V_TOTAL))
) (
  input  logic          CLOCK_50,
  input  logic          RST,
  input  logic          i_en,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic          o_pix_ce,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_active,
  output logic          o_frame_start,
  output logic          o_line_start
);
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 2");
  end
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic          pix_ce;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  clk_div_ce #(.DIV(CLK_DIV)) u_div (
    .clk (CLOCK_50),
    .rst (RST),
    .en  (i_en),
    .ce  (pix_ce),
    .vclk(VGA_CLK)
  );
  assign o_pix_ce    = pix_ce;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_BLANK_N = o_active;
  // outputs present the pixel the counters point at, then the counters advance
  always_ff @(posedge CLOCK_50)
    if (RST) begin
      h_cnt <= '0;
      v_cnt <= '0;
      o_x <= '0;
      o_y <= '0;
      o_active <= 1'b0;
      VGA_HS <= ~HS_POL;
      VGA_VS <= ~VS_POL;
      o_frame_start <= 1'b0;
      o_line_start <= 1'b0;
    end else begin
      o_frame_start <= pix_ce && h_cnt == '0 && v_cnt == '0;
      o_line_start <= pix_ce && h_cnt == '0;
      if (pix_ce) begin
        o_x <= h_cnt;
        o_y <= v_cnt;
        o_active <= h_cnt < H_ACT && v_cnt < V_ACT;
        VGA_HS <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
        VGA_VS <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
        h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + CW'(1);
        if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + CW'(1);
      end
    end
endmodule
